// File: rtl/soc_map_pkg.sv
// Shared address map, status bit positions and UART state encoding for the
// memory-side bus slave and its UART transmitter.
package soc_map_pkg;

  localparam int IO_SEL_BIT = 22;

  localparam logic [7:0] OFF_LEDS        = 8'h00;
  localparam logic [7:0] OFF_UART_DATA   = 8'h04;
  localparam logic [7:0] OFF_UART_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLES      = 8'h0C;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // IO register offset with the byte-within-word bits forced to zero.
  function automatic logic [7:0] io_offset(input logic [31:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/soc_mem_bus_if.sv
// CPU memory port: address, store data/mask and read strobe from the CPU,
// registered read data back from the memory side.
interface soc_mem_bus_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_wmask,
                  output mem_rstrb, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_wmask,
                  input mem_rstrb, output mem_rdata);
endinterface

// File: rtl/soc_uart_tx.sv
// Buffered 8N1 UART transmitter: small push FIFO with sticky overflow flag
// feeding a start/data/stop serialiser.
module soc_uart_tx
  import soc_map_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          push_ok, pop;

  uart_state_e   state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // makes room for a push.
  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign ovf     = ovf_reg;
  assign busy    = (state_reg != UART_IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && full) ovf_reg <= 1'b1;
      else if (clr_ovf) ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= UART_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= 8'hFF;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      UART_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          baud_next  = '0;
          bit_next   = '0;
          state_next = UART_START;
        end
      end
      UART_START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          state_next = UART_DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      UART_DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          shift_next = {1'b1, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = UART_STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      UART_STOP: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          state_next = UART_IDLE;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_reg)
      UART_START: tx = 1'b0;
      UART_DATA:  tx = shift_reg[0];
      default:    tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/soc_mem_bus.sv
// Memory-side slave for the CPU port: word RAM plus an IO page holding LEDs,
// a buffered UART transmitter and a free-running cycle counter.
module soc_mem_bus
  import soc_map_pkg::*;
#(
  parameter int    RAM_WORDS    = 4096,
  parameter string INIT_FILE    = "",
  parameter int    CLKS_PER_BIT = 104,
  parameter int    FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  soc_mem_bus_if.slave        bus,
  output logic [7:0]          leds,
  output logic                uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ram_rdata_reg;
  logic [31:0]   io_rdata_reg, io_rdata_next;
  logic          rd_ram_reg;
  logic [7:0]    leds_reg;
  logic [31:0]   cycles_reg;
  logic [AW-1:0] ram_idx;
  logic [7:0]    io_off;
  logic          io_sel, ram_we, io_we;
  logic [3:0]    status;
  logic          tx_busy, fifo_full, fifo_empty, tx_ovf;
  logic          unused_bits;

  assign ram_idx     = bus.mem_addr[2 +: AW];
  assign io_sel      = bus.mem_addr[IO_SEL_BIT];
  assign io_off      = io_offset(bus.mem_addr);
  assign ram_we      = !io_sel && (bus.mem_wmask != 4'b0000);
  assign io_we       = io_sel && (bus.mem_wmask != 4'b0000);
  assign unused_bits = ^bus.mem_addr;

  // Read and byte-lane write share one edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (bus.mem_rstrb && !io_sel) ram_rdata_reg <= ram[ram_idx];
    for (int i = 0; i < 4; i++) begin
      if (ram_we && bus.mem_wmask[i]) ram[ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = tx_busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = tx_ovf;
  end

  always_comb begin
    io_rdata_next = '0;
    case (io_off)
      OFF_LEDS:        io_rdata_next = {24'b0, leds_reg};
      OFF_UART_STATUS: io_rdata_next = {28'b0, status};
      OFF_CYCLES:      io_rdata_next = cycles_reg;
      default:         io_rdata_next = '0;
    endcase
  end

  // rd_ram_reg remembers which target the last strobe read, so both data
  // registers simply hold until the next strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ram_reg   <= 1'b0;
      io_rdata_reg <= '0;
      leds_reg     <= '0;
      cycles_reg   <= '0;
    end else begin
      cycles_reg <= cycles_reg + 32'd1;
      if (bus.mem_rstrb) begin
        rd_ram_reg   <= !io_sel;
        io_rdata_reg <= io_rdata_next;
      end
      if (io_we && (io_off == OFF_LEDS)) leds_reg <= bus.mem_wdata[7:0];
    end
  end

  assign bus.mem_rdata = rd_ram_reg ? ram_rdata_reg : io_rdata_reg;
  assign leds          = leds_reg;

  soc_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .rstn      (rstn),
    .push      (io_we && (io_off == OFF_UART_DATA)),
    .push_data (bus.mem_wdata[7:0]),
    .clr_ovf   (io_we && (io_off == OFF_UART_STATUS)),
    .tx        (uart_tx),
    .busy      (tx_busy),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (tx_ovf)
  );

endmodule

// File: tb/tb_soc_mem_bus.sv
// Directed and randomized checks of soc_mem_bus: RAM lanes/aliasing, IO page,
// UART framing and FIFO overflow, cycle counter and asynchronous reset.
module tb_soc_mem_bus;
  import soc_map_pkg::*;

  localparam int RAM_WORDS = 1024;
  localparam int CPB       = 4;
  localparam int FD        = 4;

  localparam logic [31:0] A_LEDS   = 32'h0040_0000;
  localparam logic [31:0] A_UDATA  = 32'h0040_0004;
  localparam logic [31:0] A_STATUS = 32'h0040_0008;
  localparam logic [31:0] A_CYCLES = 32'h0040_000C;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] leds;
  logic       uart_tx;

  soc_mem_bus_if bus ();

  soc_mem_bus #(
    .RAM_WORDS    (RAM_WORDS),
    .INIT_FILE    (""),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .leds    (leds),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference for the free-running counter: clock edges seen since reset.
  int unsigned edge_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  bit         trace_on = 1'b0;
  bit         trace_q[$];
  logic [7:0] rx_q[$];
  always @(negedge clk) if (trace_on) trace_q.push_back(uart_tx);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic rstrb);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wmask = wmask;
    bus.mem_rstrb = rstrb;
    @(negedge clk);
    bus.mem_wmask = 4'b0000;
    bus.mem_rstrb = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bus_op(addr, 32'h0, 4'b0000, 1'b1);
    data = bus.mem_rdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
    bus_op(addr, wdata, wmask, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Find start bits in the captured line and sample each bit mid-period.
  task automatic decode_trace();
    int i;
    logic [7:0] b;
    i = 0;
    rx_q.delete();
    while (i + 10*CPB <= trace_q.size()) begin
      if (trace_q[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = trace_q[i + CPB*(k+1) + CPB/2];
        chk("rx_stop_bit", 64'(trace_q[i + 9*CPB + CPB/2]), 64'd1);
        rx_q.push_back(b);
        i += 10*CPB;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c1, c2, exp_rd, last_rd, addr, wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [7:0]  tx_byte, led_model;
    logic [7:0]  pushed[6];
    logic [39:0] got_w, exp_w;
    logic [31:0] ram_model[16];
    int          lows, kind, w, bitpos;

    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    idle(2);
    chk("reset_rdata", 64'(bus.mem_rdata), 64'h0);
    chk("reset_leds", 64'(leds), 64'h0);
    chk("reset_tx", 64'(uart_tx), 64'h1);
    rstn = 1'b1;
    idle(1);

    // RAM byte lanes, hold, read-before-write, aliasing
    wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
    wr(32'h101, 32'hAAAA_AAAA, 4'b0010);
    rd(32'h100, d);
    chk("ram_lane_merge", 64'(d), 64'hDEAD_AAEF);
    wr(32'h100, 32'h1234_5678, 4'b1111);
    idle(2);
    chk("ram_rdata_hold", 64'(bus.mem_rdata), 64'hDEAD_AAEF);
    bus_op(32'h100, 32'hCAFE_F00D, 4'b1111, 1'b1);
    chk("ram_read_before_write", 64'(bus.mem_rdata), 64'h1234_5678);
    rd(32'h100, d);
    chk("ram_write_landed", 64'(d), 64'hCAFE_F00D);
    rd(32'h100 + 32'(RAM_WORDS*4), d);
    chk("ram_alias", 64'(d), 64'hCAFE_F00D);

    // LED register and unmapped IO
    wr(A_LEDS, 32'h5A5A_5A5A, 4'b0001);
    chk("leds_out", 64'(leds), 64'h5A);
    rd(A_LEDS, d);
    chk("leds_read", 64'(d), 64'h5A);
    rd(32'h0040_0010, d);
    chk("io_unmapped_read", 64'(d), 64'h0);
    rd(A_LEDS | 32'h3, d);
    chk("leds_read_lowbits", 64'(d), 64'h5A);
    rd(A_UDATA, d);
    chk("uart_data_read", 64'(d), 64'h0);
    rd(A_STATUS, d);
    chk("status_idle", 64'(d), 64'h4);

    // One frame, cycle-exact: 0x41
    tx_byte = 8'h41;
    trace_q.delete();
    #1 trace_on = 1'b1;
    wr(A_UDATA, {4{tx_byte}}, 4'b0001);
    idle(1);
    for (int k = 0; k < 10*CPB; k++) begin
      rd(A_STATUS, d);
      chk("tx_busy_in_frame", 64'(d[ST_BUSY]), 64'h1);
    end
    rd(A_STATUS, d);
    chk("status_after_frame", 64'(d), 64'h4);
    trace_on = 1'b0;
    for (int i = 0; i < 10*CPB; i++) begin
      bitpos = i / CPB;
      if (bitpos == 0)      exp_w[i] = 1'b0;
      else if (bitpos == 9) exp_w[i] = 1'b1;
      else                  exp_w[i] = tx_byte[bitpos-1];
      got_w[i] = trace_q[1 + i];
    end
    chk("tx_idle_before_start", 64'(trace_q[0]), 64'h1);
    chk("tx_waveform", 64'(got_w), 64'(exp_w));
    chk("tx_idle_after_stop", 64'(trace_q[10*CPB + 1]), 64'h1);

    // FIFO overflow: six pushes in six consecutive cycles
    trace_q.delete();
    #1 trace_on = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pushed[k] = 8'($urandom);
      wr(A_UDATA, {4{pushed[k]}}, 4'b0001);
    end
    rd(A_STATUS, d);
    chk("status_overflow", 64'(d), 64'hB);
    wr(A_STATUS, 32'h0, 4'b1111);
    rd(A_STATUS, d);
    chk("status_ovf_cleared", 64'(d), 64'h3);
    idle(5*(10*CPB + 1) + 20);
    trace_on = 1'b0;
    decode_trace();
    chk("rx_frame_count", 64'(rx_q.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk("rx_byte_order", (k < rx_q.size()) ? 64'(rx_q[k]) : 64'hFFFF, 64'(pushed[k]));
    end
    rd(A_STATUS, d);
    chk("status_drained", 64'(d), 64'h4);

    // Cycle counter
    exp_rd = edge_cnt;
    rd(A_CYCLES, c1);
    chk("cycles_absolute", 64'(c1), 64'(exp_rd));
    idle(9);
    rd(A_CYCLES, c2);
    chk("cycles_delta", 64'(c2 - c1), 64'd10);

    // Asynchronous reset in the middle of a frame
    wr(A_LEDS, 32'hC3C3_C3C3, 4'b0001);
    rd(32'h100, d);
    chk("pre_reset_rdata", 64'(d), 64'hCAFE_F00D);
    wr(A_UDATA, 32'h0, 4'b0001);
    idle(15);
    chk("tx_low_mid_frame", 64'(uart_tx), 64'h0);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_tx", 64'(uart_tx), 64'h1);
    chk("async_reset_leds", 64'(leds), 64'h0);
    chk("async_reset_rdata", 64'(bus.mem_rdata), 64'h0);
    idle(2);
    rstn = 1'b1;
    rd(A_CYCLES, d);
    chk("cycles_restart", 64'(d), 64'h0);
    trace_q.delete();
    #1 trace_on = 1'b1;
    idle(60);
    trace_on = 1'b0;
    lows = 0;
    foreach (trace_q[i]) if (trace_q[i] == 1'b0) lows++;
    chk("tx_quiet_after_reset", 64'(lows), 64'd0);
    rd(A_STATUS, d);
    chk("status_after_reset", 64'(d), 64'h4);
    last_rd = 32'h4;

    // Randomized RAM / IO traffic against a word-array model
    led_model = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ram_model[k] = $urandom;
      wr(32'(k) << 2, ram_model[k], 4'b1111);
    end
    for (int n = 0; n < 200; n++) begin
      kind  = $urandom_range(0, 9);
      rstrb = 1'($urandom_range(0, 1));
      wdata = $urandom;
      wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      if (kind <= 6 || kind == 9) begin
        if (kind == 9) rstrb = 1'b0;
        w = $urandom_range(0, 15);
        addr = (32'($urandom) & 32'hFF80_0000) | (32'($urandom_range(0, 1023)) << 12)
             | (32'(w) << 2) | 32'($urandom_range(0, 3));
        exp_rd = ram_model[w];
        bus_op(addr, wdata, wmask, rstrb);
        for (int l = 0; l < 4; l++) if (wmask[l]) ram_model[w][8*l +: 8] = wdata[8*l +: 8];
      end else if (kind == 7) begin
        addr   = A_LEDS | 32'($urandom_range(0, 3));
        exp_rd = {24'b0, led_model};
        bus_op(addr, wdata, wmask, rstrb);
        if (wmask != 4'b0000) led_model = wdata[7:0];
        chk("rand_leds_out", 64'(leds), 64'(led_model));
      end else begin
        addr   = A_LEDS | (32'($urandom_range(4, 63)) << 2);
        exp_rd = 32'h0;
        bus_op(addr, wdata, wmask, rstrb);
        chk("rand_unmapped_no_effect", 64'(leds), 64'(led_model));
      end
      if (rstrb) begin
        chk("rand_read", 64'(bus.mem_rdata), 64'(exp_rd));
        last_rd = exp_rd;
      end else begin
        chk("rand_hold", 64'(bus.mem_rdata), 64'(last_rd));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
